// File: rtl/discr_rate_buffer.sv
// discr_rate_buffer: per-period edge-rate accumulator with sequence-tagged FWFT record FIFO and drop counter
module discr_rate_buffer #(
   parameter int P_N_WIDTH    = 4,
   parameter int P_ACC_WIDTH  = 24,
   parameter int P_SEQ_WIDTH  = 8,
   parameter int P_DEPTH_LOG2 = 4
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               en,
   input  logic                               valid,
   input  logic [P_N_WIDTH-1:0]               n_pedge,
   input  logic                               update,
   input  logic                               rd_en,
   input  logic                               clr_drop,
   output logic [P_SEQ_WIDTH+P_ACC_WIDTH:0]   rd_data,
   output logic                               rd_valid,
   output logic [P_DEPTH_LOG2:0]              fifo_cnt,
   output logic [P_ACC_WIDTH-1:0]             last_rate,
   output logic [15:0]                        drop_cnt
);
   localparam int W = 1 + P_SEQ_WIDTH + P_ACC_WIDTH;
   localparam int DEPTH = 1 << P_DEPTH_LOG2;
   localparam logic [P_SEQ_WIDTH-1:0] SEQ_ONE = 1;
   localparam logic [P_DEPTH_LOG2:0] PTR_ONE = 1;
   logic [P_ACC_WIDTH-1:0]  acc_q, acc_d, sum_n, last_q, last_d;
   logic                    sat_q, sat_d, sat_n;
   logic [P_SEQ_WIDTH-1:0]  seq_q, seq_d;
   logic [P_DEPTH_LOG2:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [15:0]             drop_q, drop_d;
   logic [P_ACC_WIDTH:0]    inc, sum_w;
   logic                    push, pop, full, push_ok;
   logic [W-1:0]            record;
   logic [W-1:0]            mem_q [DEPTH];
   assign inc   = valid ? {{(P_ACC_WIDTH+1-P_N_WIDTH){1'b0}}, n_pedge} : '0;
   assign sum_w = {1'b0, acc_q} + inc;
   assign sat_n = sum_w[P_ACC_WIDTH] | sat_q;
   assign sum_n = sat_n ? '1 : sum_w[P_ACC_WIDTH-1:0];
   assign record = {sat_n, seq_q, sum_n};
   assign rd_valid = wr_ptr_q != rd_ptr_q;
   assign full = (wr_ptr_q[P_DEPTH_LOG2] != rd_ptr_q[P_DEPTH_LOG2]) &&
                 (wr_ptr_q[P_DEPTH_LOG2-1:0] == rd_ptr_q[P_DEPTH_LOG2-1:0]);
   assign pop = rd_en & rd_valid;
   assign push_ok = push & (~full | pop);
   assign fifo_cnt = wr_ptr_q - rd_ptr_q;
   assign rd_data = rd_valid ? mem_q[rd_ptr_q[P_DEPTH_LOG2-1:0]] : '0;
   assign last_rate = last_q;
   assign drop_cnt = drop_q;
   // Accumulate the period, close it on update, and work out pointer/drop movement
   always_comb begin
      acc_d = sum_n;
      sat_d = sat_n;
      seq_d = seq_q;
      last_d = last_q;
      push = 1'b0;
      if (!en) begin
         acc_d = '0;
         sat_d = 1'b0;
      end else if (update) begin
         acc_d = '0;
         sat_d = 1'b0;
         seq_d = seq_q + SEQ_ONE;
         last_d = sum_n;
         push = 1'b1;
      end
      wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      drop_d = clr_drop ? '0 : (push & ~push_ok & (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
   end
   // State registers, cleared asynchronously so the FIFO empties at once on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         sat_q <= 1'b0;
         seq_q <= '0;
         last_q <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         drop_q <= '0;
      end else begin
         acc_q <= acc_d;
         sat_q <= sat_d;
         seq_q <= seq_d;
         last_q <= last_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         drop_q <= drop_d;
      end
   end
   // Record storage; contents need no reset since the pointers gate visibility
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q[P_DEPTH_LOG2-1:0]] <= record;
   end
endmodule
